// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings, SRAM slave FSM states and transfer decode helpers.
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        SIZE_BYTE = 3'd0,
        SIZE_HALF = 3'd1,
        SIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'b00,
        RESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_e;

    // Oversized or misaligned transfers are answered with ERROR and never reach memory.
    function automatic logic is_illegal(input logic [2:0] size, input logic [1:0] offset);
        return (size > SIZE_WORD) ||
               (size == SIZE_HALF && offset[0]) ||
               (size == SIZE_WORD && offset != 2'b00);
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: return 4'b0001 << offset;
            SIZE_HALF: return offset[1] ? 4'b1100 : 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_sram_core.sv
// Single-port word-wide SRAM with per-byte write enables and asynchronous read.
module ahb_sram_core
    import ahb_lite_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM responder: address capture, wait-state FSM, two-cycle ERROR and byte-lane writes.
module ahb_lite_sram_slave
    import ahb_lite_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e            state;
    logic [ADDR_W-1:0] word_addr;
    logic [1:0]        offset;
    logic [2:0]        size;
    logic              write;
    logic [3:0]        wait_cnt;
    logic              ready_q;
    hresp_e            resp_q;
    logic [31:0]       rdata_q;

    logic              accept;
    logic              illegal;
    logic [3:0]        we;
    logic [31:0]       mem_rdata;
    logic              unused_bits;

    always_comb begin
        accept  = HSEL & HREADY & HTRANS[1];
        illegal = is_illegal(HSIZE, HADDR[1:0]);
        we      = '0;
        if (state == ST_DATA && write && !HRESET) begin
            we = lane_mask(size, offset);
        end
    end

    assign unused_bits = ^{HBURST, HTRANS[0], HADDR[31:ADDR_W+2]};

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= ST_IDLE;
            ready_q   <= 1'b1;
            resp_q    <= RESP_OKAY;
            rdata_q   <= '0;
            wait_cnt  <= '0;
            word_addr <= '0;
            offset    <= '0;
            size      <= '0;
            write     <= 1'b0;
        end else begin
            if (state == ST_DATA && !write) begin
                rdata_q <= mem_rdata;
            end
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state   <= ST_DATA;
                        ready_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state   <= ST_ERR2;
                    ready_q <= 1'b1;
                end
                // IDLE, DATA and ERR2 all complete a beat and may take the next address phase
                default: begin
                    if (accept) begin
                        word_addr <= HADDR[ADDR_W+1:2];
                        offset    <= HADDR[1:0];
                        size      <= HSIZE;
                        write     <= HWRITE;
                        if (illegal) begin
                            state   <= ST_ERR1;
                            ready_q <= 1'b0;
                            resp_q  <= RESP_ERROR;
                        end else if (WAIT_STATES > 0) begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                            ready_q  <= 1'b0;
                            resp_q   <= RESP_OKAY;
                        end else begin
                            state   <= ST_DATA;
                            ready_q <= 1'b1;
                            resp_q  <= RESP_OKAY;
                        end
                    end else begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                        resp_q  <= RESP_OKAY;
                    end
                end
            endcase
        end
    end

    ahb_sram_core #(
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk   (HCLK),
        .we    (we),
        .addr  (word_addr),
        .wdata (HWDATA),
        .rdata (mem_rdata)
    );

    assign HREADYOUT = ready_q;
    assign HRESP     = resp_q;
    // Asynchronous read in the data phase sees a write committed at the previous edge
    assign HRDATA    = (state == ST_DATA && !write) ? mem_rdata : rdata_q;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Randomised bench for two SRAM slaves (0 and 2 wait states) against a word-array reference model.
module tb_ahb_lite_sram_slave;

    typedef struct packed {
        bit        sel;
        bit [1:0]  trans;
        bit        write;
        bit [2:0]  size;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit        stall;
    } xfer_t;

    logic        clk = 1'b0;
    logic        HRESET;
    logic        hsel      [2];
    logic [31:0] haddr     [2];
    logic [1:0]  htrans    [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [2:0]  hburst    [2];
    logic [31:0] hwdata    [2];
    logic        ext       [2];
    logic        hreadyout [2];
    logic [1:0]  hresp     [2];
    logic [31:0] hrdata    [2];
    logic        hready0, hready1;

    logic [31:0] mem_m   [2][1024];
    logic [31:0] last_rd [2];
    xfer_t       txq[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    assign hready0 = hreadyout[0] & ext[0];
    assign hready1 = hreadyout[1] & ext[1];

    ahb_lite_sram_slave #(.ADDR_W(10), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESET(HRESET), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]), .HWDATA(hwdata[0]),
        .HREADY(hready0), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0])
    );

    ahb_lite_sram_slave #(.ADDR_W(10), .WAIT_STATES(2)) dut1 (
        .HCLK(clk), .HRESET(HRESET), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]), .HWDATA(hwdata[1]),
        .HREADY(hready1), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1])
    );

    function automatic int ws(input int idx);
        return (idx == 0) ? 0 : 2;
    endfunction

    function automatic bit bad_xfer(input bit [2:0] size, input bit [31:0] addr);
        if (size > 3'd2) return 1'b1;
        return (addr % (32'd1 << size)) != 0;
    endfunction

    function automatic int widx(input bit [31:0] addr);
        return int'((addr >> 2) % 1024);
    endfunction

    // Reference write: the 2**size bytes starting at the byte offset take the matching HWDATA bytes.
    task automatic model_write(input int idx, input xfer_t x);
        int w = widx(x.addr);
        int off = int'(x.addr % 4);
        for (int b = off; b < off + (1 << x.size); b++) begin
            mem_m[idx][w][8*b +: 8] = x.wdata[8*b +: 8];
        end
    endtask

    function automatic xfer_t mk(input bit write, input bit [2:0] size, input bit [31:0] addr,
                                 input bit [31:0] wdata);
        xfer_t x;
        x.sel = 1'b1; x.trans = 2'b10; x.write = write; x.size = size;
        x.addr = addr; x.wdata = wdata; x.stall = 1'b0;
        return x;
    endfunction

    task automatic drive_idle(input int idx);
        hsel[idx] = 1'b0; htrans[idx] = 2'b00; haddr[idx] = $urandom();
        hwrite[idx] = 1'b0; hsize[idx] = 3'd0; ext[idx] = 1'b1;
    endtask

    task automatic next_addr(input int idx, output xfer_t a, output bit a_valid, input bit d_valid);
        a = '0;
        a_valid = (txq.size() != 0);
        if (a_valid) begin
            a = txq.pop_front();
            hsel[idx] = a.sel; htrans[idx] = a.trans; haddr[idx] = a.addr;
            hwrite[idx] = a.write; hsize[idx] = a.size; hburst[idx] = 3'($urandom());
            ext[idx] = !(a.stall && !d_valid);
        end else begin
            drive_idle(idx);
        end
    endtask

    // Runs everything in txq as a pipelined stream on one slave, checking every cycle.
    task automatic run_queue(input int idx);
        xfer_t a, d;
        bit a_valid, d_valid = 1'b0, hr, exp_err;
        int low = 0, exp_low, cyc = 0, limit;
        logic r; logic [1:0] rs; logic [31:0] rd, exp_rd;
        limit = 20 * txq.size() + 20;
        d = '0;
        next_addr(idx, a, a_valid, d_valid);
        while (a_valid || d_valid) begin
            if (cyc > limit) begin
                n_checks++; n_fail++;
                $display("FAIL timeout slave%0d: cycles=%0d required<=%0d", idx, cyc, limit);
                break;
            end
            cyc++;
            @(negedge clk);
            r = hreadyout[idx]; rs = hresp[idx]; rd = hrdata[idx];
            if (d_valid) begin
                exp_err = bad_xfer(d.size, d.addr);
                exp_low = exp_err ? 1 : ws(idx);
                n_checks++;
                if (rs !== (exp_err ? 2'b01 : 2'b00)) begin
                    n_fail++;
                    $display("FAIL hresp slave%0d addr=%h size=%0d: got %b required %b",
                             idx, d.addr, d.size, rs, exp_err ? 2'b01 : 2'b00);
                end
                if (r !== 1'b1) begin
                    low++;
                    n_checks++;
                    if (low > exp_low) begin
                        n_fail++;
                        $display("FAIL wait_len slave%0d addr=%h: low cycles %0d required %0d",
                                 idx, d.addr, low, exp_low);
                    end
                end else begin
                    n_checks++;
                    if (low != exp_low) begin
                        n_fail++;
                        $display("FAIL wait_len slave%0d addr=%h: low cycles %0d required %0d",
                                 idx, d.addr, low, exp_low);
                    end
                end
                if (r === 1'b1 && !exp_err && !d.write) begin
                    exp_rd = mem_m[idx][widx(d.addr)];
                    n_checks++;
                    if (rd !== exp_rd) begin
                        n_fail++;
                        $display("FAIL hrdata slave%0d addr=%h: got %h required %h", idx, d.addr, rd, exp_rd);
                    end
                    last_rd[idx] = rd;
                end else begin
                    n_checks++;
                    if (rd !== last_rd[idx]) begin
                        n_fail++;
                        $display("FAIL hrdata_hold slave%0d: got %h required %h", idx, rd, last_rd[idx]);
                    end
                end
                if (r === 1'b1 && !exp_err && d.write) model_write(idx, d);
            end else begin
                n_checks++;
                if (r !== 1'b1 || rs !== 2'b00 || rd !== last_rd[idx]) begin
                    n_fail++;
                    $display("FAIL idle_resp slave%0d: ready=%b resp=%b rdata=%h required 1 00 %h",
                             idx, r, rs, rd, last_rd[idx]);
                end
            end
            hr = r & ext[idx];
            @(posedge clk); #1;
            if (hr) begin
                d_valid = 1'b0;
                if (a_valid && a.sel && a.trans[1]) begin
                    d = a; d_valid = 1'b1; low = 0;
                end
                hwdata[idx] = (d_valid && d.write) ? d.wdata : $urandom();
                next_addr(idx, a, a_valid, d_valid);
            end else begin
                ext[idx] = 1'b1;
            end
        end
        txq.delete();
        drive_idle(idx);
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (hreadyout[i] !== 1'b1) begin n_fail++; $display("FAIL reset_ready slave%0d: got %b required 1", i, hreadyout[i]); end
            n_checks++;
            if (hresp[i] !== 2'b00) begin n_fail++; $display("FAIL reset_resp slave%0d: got %b required 00", i, hresp[i]); end
            n_checks++;
            if (hrdata[i] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata slave%0d: got %h required 0", i, hrdata[i]); end
            last_rd[i] = 32'h0;
        end
        HRESET = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_preload();
        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < 64; w++) txq.push_back(mk(1'b1, 3'd2, 32'(w * 4), $urandom()));
            run_queue(i);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            txq.push_back(mk(1'b1, 3'd2, 32'h10, 32'hDEADBEEF));
            txq.push_back(mk(1'b0, 3'd2, 32'h10, 32'h0));
            run_queue(i);
            n_checks++;
            if (last_rd[i] !== 32'hDEADBEEF) begin
                n_fail++; $display("FAIL raw_readback slave%0d: got %h required deadbeef", i, last_rd[i]);
            end
        end
    endtask

    task automatic test_byte_lanes();
        txq.push_back(mk(1'b1, 3'd0, 32'h11, 32'hFFFF55FF));
        txq.push_back(mk(1'b1, 3'd1, 32'h12, 32'hA5A51111));
        txq.push_back(mk(1'b0, 3'd2, 32'h10, 32'h0));
        run_queue(1);
        n_checks++;
        if (last_rd[1] !== 32'hA5A555EF) begin
            n_fail++; $display("FAIL lane_merge: got %h required a5a555ef", last_rd[1]);
        end
    endtask

    task automatic test_error();
        txq.push_back(mk(1'b1, 3'd1, 32'h13, 32'h00000000));
        txq.push_back(mk(1'b1, 3'd3, 32'h10, 32'h00000000));
        txq.push_back(mk(1'b0, 3'd2, 32'h10, 32'h0));
        run_queue(1);
        n_checks++;
        if (last_rd[1] !== 32'hA5A555EF) begin
            n_fail++; $display("FAIL error_no_write: got %h required a5a555ef", last_rd[1]);
        end
    endtask

    // Slave 0 is reset in its write DATA cycle, slave 1 in its first WAIT cycle.
    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            hsel[i] = 1'b1; htrans[i] = 2'b10; haddr[i] = 32'h20;
            hwrite[i] = 1'b1; hsize[i] = 3'd2; ext[i] = 1'b1;
        end
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            drive_idle(i);
            hwdata[i] = 32'h12345678;
        end
        @(negedge clk);
        n_checks++;
        if (hreadyout[1] !== 1'b0) begin n_fail++; $display("FAIL mid_wait_ready: got %b required 0", hreadyout[1]); end
        HRESET = 1'b1;
        @(posedge clk); #1;
        HRESET = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (hreadyout[i] !== 1'b1 || hresp[i] !== 2'b00 || hrdata[i] !== 32'h0) begin
                n_fail++;
                $display("FAIL mid_reset slave%0d: ready=%b resp=%b rdata=%h required 1 00 00000000",
                         i, hreadyout[i], hresp[i], hrdata[i]);
            end
            last_rd[i] = 32'h0;
        end
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            txq.push_back(mk(1'b0, 3'd2, 32'h20, 32'h0));
            run_queue(i);
            n_checks++;
            if (last_rd[i] === 32'h12345678) begin
                n_fail++; $display("FAIL reset_write_dropped slave%0d: got %h required %h", i, last_rd[i], mem_m[i][8]);
            end
        end
    endtask

    task automatic test_random(input int idx, input int n);
        xfer_t x;
        int r;
        for (int k = 0; k < n; k++) begin
            r = $urandom_range(0, 9);
            x.sel   = 1'b1;
            x.trans = $urandom_range(0, 1) ? 2'b10 : 2'b11;
            x.write = 1'($urandom_range(0, 1));
            x.size  = (r == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            x.addr  = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 63)) << 2)
                    | 32'($urandom_range(0, 3));
            x.wdata = $urandom();
            x.stall = ($urandom_range(0, 7) == 0);
            if (r == 1) begin
                if ($urandom_range(0, 1)) x.sel = 1'b0;
                else x.trans = 2'($urandom_range(0, 1));
            end
            txq.push_back(x);
        end
        run_queue(idx);
    endtask

    initial begin
        HRESET = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_idle(i);
            hburst[i] = 3'd0;
            hwdata[i] = 32'h0;
            last_rd[i] = 32'h0;
        end
        test_reset();
        test_preload();
        test_back_to_back();
        test_byte_lanes();
        test_error();
        test_reset_mid();
        test_random(0, 300);
        test_random(1, 300);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
